// File: rtl/rv_pkg.sv
// Shared constants for the integer register-file write path.
//   REG_IDX_W : width of an architectural register index
//   XLEN      : register data width
//   REG_ZERO  : index of the hard-wired zero register x0
package rv_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

endpackage : rv_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   req[1:0]   : request lines (bit 0 = requester 0)
//   advance    : a grant was consumed this cycle; move priority
//   grant[1:0] : one-hot grant, or zero when nothing is requested
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // ptr = 0 : requester 0 wins a tie; ptr = 1 : requester 1 wins a tie
    logic ptr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After a grant the other requester gets priority; idle cycles keep it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (advance && (grant != 2'b00)) begin
            ptr <= grant[0];
        end
    end

endmodule : rr_arb2

// File: rtl/rf_wb_sched.sv
// Write-port scheduler and hazard scoreboard for the integer register file.
// Two writeback sources (wb0 = ALU, wb1 = load unit) share the single
// write port via round-robin arbitration; a busy-bit scoreboard stalls
// issue on RAW/WAW hazards and on reads that would collide with the
// write launched in the same cycle.
// Ports:
//   clk, rst_n                      : clock, synchronous active-low reset
//   iss_valid/rs1/rs2/rd/wen        : instruction presented for issue
//   iss_ready                       : issue accepted (combinational)
//   wb0_valid/addr/data, wb0_ready  : ALU writeback handshake
//   wb1_valid/addr/data, wb1_ready  : load writeback handshake
//   rf_we, rf_wa, rf_dw             : registered register-file write port
//   busy                            : scoreboard, bit i = write to xi pending
module rf_wb_sched
    import rv_pkg::*;
#(
    parameter int NREG = 32,
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rs1,
    input  logic [REG_IDX_W-1:0] iss_rs2,
    input  logic [REG_IDX_W-1:0] iss_rd,
    input  logic                 iss_wen,
    output logic                 iss_ready,
    input  logic                 wb0_valid,
    input  logic [REG_IDX_W-1:0] wb0_addr,
    input  logic [XLEN-1:0]      wb0_data,
    output logic                 wb0_ready,
    input  logic                 wb1_valid,
    input  logic [REG_IDX_W-1:0] wb1_addr,
    input  logic [XLEN-1:0]      wb1_data,
    output logic                 wb1_ready,
    output logic                 rf_we,
    output logic [31:0]          rf_wa,
    output logic [XLEN-1:0]      rf_dw,
    output logic [NREG-1:0]      busy
);

    logic [1:0]           req;
    logic [1:0]           grant;
    logic                 wb_xfer;
    logic [REG_IDX_W-1:0] win_addr;
    logic [XLEN-1:0]      win_data;
    logic                 launch;
    logic                 iss_xfer;
    logic                 raw_haz;
    logic                 waw_haz;
    logic                 rd_col;
    logic [NREG-1:0]      busy_next;

    logic                 we_p1;
    logic [REG_IDX_W-1:0] wa_p1;
    logic [XLEN-1:0]      dw_p1;
    logic [NREG-1:0]      busy_q;

    assign req = {wb1_valid, wb0_valid};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (wb_xfer),
        .grant   (grant)
    );

    // Ready equals grant, and grant only exists when valid is high,
    // so every grant is a completed transfer.
    assign wb0_ready = grant[0];
    assign wb1_ready = grant[1];
    assign wb_xfer   = grant[0] | grant[1];
    assign win_addr  = grant[1] ? wb1_addr : wb0_addr;
    assign win_data  = grant[1] ? wb1_data : wb0_data;

    // A write to x0 is acknowledged but never reaches the file.
    assign launch = wb_xfer && (win_addr != REG_ZERO);

    // Hazard checks use the pre-edge scoreboard. A read of the register
    // being written this cycle is suppressed by the file, so it stalls too.
    always_comb begin
        raw_haz = busy_q[iss_rs1] | busy_q[iss_rs2];
        waw_haz = iss_wen & busy_q[iss_rd];
        rd_col  = we_p1 && (((iss_rs1 != REG_ZERO) && (wa_p1 == iss_rs1)) ||
                            ((iss_rs2 != REG_ZERO) && (wa_p1 == iss_rs2)));
    end

    assign iss_ready = !(raw_haz || waw_haz || rd_col);
    assign iss_xfer  = iss_valid && iss_ready;

    // Clear is applied before set so a new producer keeps ownership
    // when both hit the same register on one edge.
    always_comb begin
        busy_next = busy_q;
        if (wb_xfer) begin
            busy_next[win_addr] = 1'b0;
        end
        if (iss_xfer && iss_wen && (iss_rd != REG_ZERO)) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // ---- stage p0 -> p1: writeback launch and scoreboard update ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            we_p1  <= 1'b0;
            wa_p1  <= '0;
            dw_p1  <= '0;
        end else begin
            busy_q <= busy_next;
            we_p1  <= launch;
            if (launch) begin
                wa_p1 <= win_addr;
                dw_p1 <= win_data;
            end
        end
    end

    assign rf_we = we_p1;
    assign rf_wa = {{(32-REG_IDX_W){1'b0}}, wa_p1};
    assign rf_dw = dw_p1;
    assign busy  = busy_q;

endmodule : rf_wb_sched
